// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: word width, reset PC,
// HLT opcode and the instruction-fetch state encoding.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] CPU_RESET_PC    = 16'h0000;
  localparam logic [3:0]        CPU_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one instruction slot with load, hold and squash.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              squash,
  input  logic              consume,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_in,
  output logic              valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc
);

  // Squash wins over load; a load may coincide with consumption of the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time over
// req/ack + rvalid, fills IF/ID, and handles stall, flush and HLT.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = CPU_RESET_PC,
  parameter logic [3:0]        HALT_OPCODE = CPU_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] pc_cur,
  input  logic [WORD_W-1:0] pc_next,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic              halted
);

  fetch_state_t      state, state_n;
  logic [WORD_W-1:0] pc, pc_n;
  logic              drop, drop_n;
  logic              load;
  logic              accepted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
    end
  end

  assign pc_cur    = pc;
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign imem_req  = (state == S_REQ) && !(ifid_valid && stall) && !rst;
  assign accepted  = imem_req && imem_ack;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    load    = 1'b0;
    unique case (state)
      S_REQ: begin
        if (accepted) begin
          state_n = S_WAIT;
          if (flush) drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_n = 1'b0;
          if (flush || drop) begin
            state_n = S_REQ;
          end else begin
            load = 1'b1;
            if (imem_rdata[15:12] == HALT_OPCODE) begin
              state_n = S_HALT;
            end else begin
              state_n = S_REQ;
              pc_n    = pc_next;
            end
          end
        end else if (flush) begin
          drop_n = 1'b1;
        end
      end
      S_HALT: begin
        if (flush) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
    if (flush) pc_n = flush_pc;
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .squash   (flush),
    .consume  (ifid_valid && !stall),
    .instr_in (imem_rdata),
    .pc_in    (pc),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc       (ifid_pc)
  );

  // Requests are only issued when IF/ID will be free, so a capture never overwrites a live entry.
  capture_into_free_slot: assert property (@(posedge clk) disable iff (rst)
    load |-> (!ifid_valid || !stall));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a transaction-level model
// of the PC, the single outstanding fetch and the IF/ID slot.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_cur, pc_next;
  logic        stall = 1'b0, flush = 1'b0;
  logic [15:0] flush_pc = '0;
  logic        imem_req, imem_ack = 1'b0, imem_rvalid = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0;
  logic        ifid_valid, halted;
  logic [15:0] ifid_instr, ifid_pc;

  always #5 clk = ~clk;

  // PC control: sequential next PC with natural 16-bit wrap
  assign pc_next = pc_cur + 16'd2;

  fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .halted(halted)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];

  // reference model state
  logic [15:0] m_pc = 16'h0000;
  logic        m_valid = 1'b0, m_halted = 1'b0;
  logic [15:0] m_instr = '0, m_ipc = '0;
  logic        os_busy = 1'b0, os_drop = 1'b0;
  logic [15:0] os_addr = '0;
  int          os_wait = 0;

  // stimulus knobs
  int          k_stall = 0, k_flush = 0, k_ack = 100, k_lat = 1;
  logic        k_no_halt = 1'b1;
  int          s_force = 0;
  logic        f_flush = 1'b0, f_flush_on_rv = 1'b0, f_halt_data = 1'b0, f_stray_rv = 1'b0;
  logic [15:0] f_flush_pc = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    os_busy = 1'b0; os_drop = 1'b0; os_wait = 0;
  endtask

  task automatic step();
    logic rv, fl, ak, exp_req;
    logic [15:0] fp, rd;
    @(negedge clk);
    if (s_force > 0) begin stall = 1'b1; s_force--; end
    else stall = ($urandom_range(99) < k_stall);
    rv = 1'b0;
    rd = 16'($urandom);
    if (k_no_halt && rd[15:12] == 4'hF) rd[15:12] = 4'h0;
    if (os_busy) begin
      if (os_wait == 0) rv = 1'b1;
      else os_wait--;
    end
    if (f_stray_rv && !os_busy) begin rv = 1'b1; f_stray_rv = 1'b0; end
    if (rv && os_busy && f_halt_data) begin rd = 16'hF000; f_halt_data = 1'b0; end
    fl = 1'b0;
    fp = 16'($urandom);
    if (f_flush || (f_flush_on_rv && rv && os_busy)) begin
      fl = 1'b1; fp = f_flush_pc; f_flush = 1'b0; f_flush_on_rv = 1'b0;
    end else if ($urandom_range(99) < k_flush) begin
      fl = 1'b1;
    end
    flush = fl; flush_pc = fp; imem_rvalid = rv; imem_rdata = rd; imem_ack = 1'b0;
    #1;
    exp_req = !m_halted && !os_busy && !(m_valid && stall);
    chk("imem_req", 16'(imem_req), 16'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_cur", pc_cur, m_pc);
    chk("ifid_valid", 16'(ifid_valid), 16'(m_valid));
    chk("halted", 16'(halted), 16'(m_halted));
    if (m_valid) begin
      chk("ifid_instr_hold", ifid_instr, m_instr);
      chk("ifid_pc_hold", ifid_pc, m_ipc);
    end
    ak = exp_req && ($urandom_range(99) < k_ack);
    imem_ack = ak;
    if (fl) begin
      m_valid = 1'b0; m_pc = fp; m_halted = 1'b0;
      if (os_busy) begin
        if (rv) begin os_busy = 1'b0; os_drop = 1'b0; end
        else os_drop = 1'b1;
      end else if (ak) begin
        os_busy = 1'b1; os_drop = 1'b1; os_wait = $urandom_range(k_lat - 1, 0);
      end
    end else begin
      if (os_busy && rv) begin
        os_busy = 1'b0;
        if (!os_drop) begin
          sb.push_back({rd, os_addr});
          m_valid = 1'b1; m_instr = rd; m_ipc = os_addr;
          if (rd[15:12] == 4'hF) m_halted = 1'b1;
          else m_pc = m_pc + 16'd2;
        end
        os_drop = 1'b0;
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
      if (ak) begin
        os_busy = 1'b1; os_drop = 1'b0; os_addr = m_pc;
        os_wait = $urandom_range(k_lat - 1, 0);
      end
    end
  endtask

  // monitor: each new IF/ID entry must match the oldest expected capture
  initial begin
    logic prev_v;
    logic [31:0] e;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && ifid_valid && !prev_v) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL capture_unexpected act=%h@%h exp=none", ifid_instr, ifid_pc);
        end else begin
          e = sb.pop_front();
          chk("cap_instr", ifid_instr, e[31:16]);
          chk("cap_pc", ifid_pc, e[15:0]);
        end
      end
      prev_v = ifid_valid;
    end
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pc", pc_cur, 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 16'(ifid_valid), 16'h0);
    chk("rst_instr", ifid_instr, 16'h0000);
    chk("rst_ifid_pc", ifid_pc, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0);
    rst = 1'b0;

    // sequential fetch with 1-cycle memory
    repeat (12) step();

    // stall hold while IF/ID is occupied
    n = 0;
    while (!m_valid && n < 20) begin step(); n++; end
    chk("stall_setup", 16'(m_valid), 16'h1);
    s_force = 3;
    repeat (6) step();

    // flush while a fetch is in S_WAIT
    n = 0;
    while (!(os_busy && !m_valid) && n < 20) begin step(); n++; end
    chk("wait_setup", 16'(os_busy), 16'h1);
    os_wait = 2;
    f_flush = 1'b1; f_flush_pc = 16'h0100;
    repeat (10) step();

    // flush coincident with rvalid
    n = 0;
    while (!(os_busy && os_wait == 0) && n < 20) begin step(); n++; end
    f_flush_on_rv = 1'b1; f_flush_pc = 16'h0040;
    repeat (8) step();

    // HLT at 0x0010, then redirect out of halt
    f_flush = 1'b1; f_flush_pc = 16'h0010;
    step();
    f_halt_data = 1'b1;
    n = 0;
    while (!m_halted && n < 20) begin step(); n++; end
    chk("halt_reached", 16'(m_halted), 16'h1);
    repeat (12) step();
    chk("halt_pc", pc_cur, 16'h0010);
    chk("halt_instr", ifid_instr, 16'hF000);
    f_flush = 1'b1; f_flush_pc = 16'h0020;
    repeat (8) step();

    // odd address and wrap through 0xFFFF
    f_flush = 1'b1; f_flush_pc = 16'hFFFB;
    repeat (10) step();

    // async reset while waiting for a response, then a stray rvalid
    n = 0;
    while (!os_busy && n < 20) begin step(); n++; end
    os_wait = 5;
    @(posedge clk);
    #3;
    rst = 1'b1; imem_ack = 1'b0; imem_rvalid = 1'b0; flush = 1'b0;
    #1;
    chk("arst_valid", 16'(ifid_valid), 16'h0);
    chk("arst_req", 16'(imem_req), 16'h0);
    chk("arst_pc", pc_cur, 16'h0000);
    chk("arst_halted", 16'(halted), 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    f_stray_rv = 1'b1;
    repeat (10) step();

    // randomized traffic
    k_stall = 30; k_flush = 5; k_ack = 70; k_lat = 3; k_no_halt = 1'b0;
    repeat (3000) step();
    k_flush = 0; k_stall = 0; k_ack = 100; k_no_halt = 1'b1;
    f_flush = 1'b1; f_flush_pc = 16'h0200;
    repeat (12) step();

    @(posedge clk);
    #3;
    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
